// File: rtl/prim_assembly.sv
// Primitive assembly: groups decoded vertices into points/lines/triangles and
// queues them in a small FIFO toward the rasterizer, stalling the decoder when full.
module prim_assembly #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [63:0] Vertex,
    input  logic        NewVertex,
    input  logic        StartPrimitive,
    input  logic [3:0]  PrimitiveType,
    input  logic        EndPrimitive,
    input  logic        Draw,
    output logic        Stall,
    output logic        PrimValid,
    input  logic        PrimReady,
    output logic [3:0]  PrimType,
    output logic [63:0] PrimV0,
    output logic [63:0] PrimV1,
    output logic [63:0] PrimV2,
    output logic        Error
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    localparam logic [3:0] TypePoints   = 4'h0;
    localparam logic [3:0] TypeLines    = 4'h1;
    localparam logic [3:0] TypeTris     = 4'h2;
    localparam logic [3:0] TypeTriStrip = 4'h3;
    localparam logic [3:0] TypeMarker   = 4'hF;

    typedef enum logic [0:0] {StIdle, StCollect} state_e;

    state_e          state_q, state_d;
    logic [3:0]      type_q, type_d;
    logic [63:0]     a_q, a_d, b_q, b_d;
    logic [1:0]      vcnt_q, vcnt_d;
    logic            parity_q, parity_d;
    logic            err_q, err_d;

    logic [195:0]    mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            accept, push, pop;
    logic [195:0]    push_data, head;

    function automatic logic [195:0] entry(input logic [3:0] t, input logic [63:0] v0,
                                           input logic [63:0] v1, input logic [63:0] v2);
        return {t, v2, v1, v0};
    endfunction

    assign Stall     = (cnt_q == CntFull);
    assign PrimValid = (cnt_q != '0);
    assign accept    = ~Stall;
    assign pop       = PrimValid & PrimReady;
    assign Error     = err_q;

    assign head     = PrimValid ? mem_q[rd_ptr_q] : '0;
    assign PrimType = head[195:192];
    assign PrimV2   = head[191:128];
    assign PrimV1   = head[127:64];
    assign PrimV0   = head[63:0];

    // Assembly FSM; only the highest-priority pulse of an accepted cycle is acted on.
    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        a_d       = a_q;
        b_d       = b_q;
        vcnt_d    = vcnt_q;
        parity_d  = parity_q;
        err_d     = 1'b0;
        push      = 1'b0;
        push_data = '0;
        if (accept) begin
            if (StartPrimitive) begin
                err_d    = (state_q == StCollect) && (vcnt_q != 2'd0);
                state_d  = StCollect;
                type_d   = PrimitiveType;
                vcnt_d   = 2'd0;
                parity_d = 1'b0;
                a_d      = '0;
                b_d      = '0;
            end else if (EndPrimitive) begin
                if (state_q == StCollect) begin
                    state_d = StIdle;
                    // A strip with two or more vertices is a complete primitive.
                    err_d   = (type_q == TypeTriStrip) ? (vcnt_q == 2'd1) : (vcnt_q != 2'd0);
                end
            end else if (Draw) begin
                push      = 1'b1;
                push_data = entry(TypeMarker, '0, '0, '0);
            end else if (NewVertex) begin
                if (state_q == StIdle) begin
                    err_d = 1'b1;
                end else begin
                    unique case (type_q)
                        TypePoints: begin
                            push      = 1'b1;
                            push_data = entry(TypePoints, Vertex, '0, '0);
                        end
                        TypeLines: begin
                            if (vcnt_q == 2'd0) begin
                                a_d    = Vertex;
                                vcnt_d = 2'd1;
                            end else begin
                                push      = 1'b1;
                                push_data = entry(TypeLines, a_q, Vertex, '0);
                                vcnt_d    = 2'd0;
                            end
                        end
                        TypeTris: begin
                            if (vcnt_q == 2'd0) begin
                                a_d    = Vertex;
                                vcnt_d = 2'd1;
                            end else if (vcnt_q == 2'd1) begin
                                b_d    = Vertex;
                                vcnt_d = 2'd2;
                            end else begin
                                push      = 1'b1;
                                push_data = entry(TypeTris, a_q, b_q, Vertex);
                                vcnt_d    = 2'd0;
                            end
                        end
                        TypeTriStrip: begin
                            if (vcnt_q == 2'd0) begin
                                a_d    = Vertex;
                                vcnt_d = 2'd1;
                            end else if (vcnt_q == 2'd1) begin
                                b_d    = Vertex;
                                vcnt_d = 2'd2;
                            end else begin
                                // Swap the first two slots on odd triangles to keep winding.
                                push      = 1'b1;
                                push_data = parity_q ? entry(TypeTris, b_q, a_q, Vertex)
                                                     : entry(TypeTris, a_q, b_q, Vertex);
                                a_d       = b_q;
                                b_d       = Vertex;
                                parity_d  = ~parity_q;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q  <= StIdle;
            type_q   <= 4'h0;
            a_q      <= '0;
            b_q      <= '0;
            vcnt_q   <= 2'd0;
            parity_q <= 1'b0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            a_q      <= a_d;
            b_q      <= b_d;
            vcnt_q   <= vcnt_d;
            parity_q <= parity_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the count is zero.
    always_ff @(posedge CLK) begin
        if (RESET_N && push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule
